aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 214 +++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 inverse cipher: expands the key one word per cycle,
// then runs one inverse round per cycle and hands the plaintext out with valid/ready.
module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [127:0]   out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);
  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] NK6 = 6'(Nk);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_KEXP = 2'd1, S_ROUND = 2'd2, S_DONE = 2'd3} state_t;

  state_t         r_state;
  logic [127:0]   r_blk;
  logic [127:0]   r_out;
  logic [31:0]    r_w [NW];
  logic [5:0]     r_idx;
  logic [3:0]     r_rnd;
  logic [2:0]     r_kmod;
  logic [7:0]     r_rcon;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [31:0]    w_prev;
  logic [31:0]    w_temp;
  logic [31:0]    w_new_word;
  logic [127:0]   w_rk;
  logic [127:0]   w_isr;
  logic [127:0]   w_isb;
  logic [127:0]   w_ark;
  logic [127:0]   w_imc;
  logic [127:0]   w_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  cf [4];
    logic [7:0]  b;
    logic [31:0] res;
    cf[0] = 8'h0e;
    cf[1] = 8'h0b;
    cf[2] = 8'h0d;
    cf[3] = 8'h09;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gf_mul(cf[(j - r + 4) % 4], col[31-8*j -: 8]);
      res[31-8*r -: 8] = b;
    end
    return res;
  endfunction

  // Next key-schedule word w[r_idx] from w[r_idx-1] and w[r_idx-Nk].
  always_comb begin
    w_prev = r_w[r_idx - 6'd1];
    if (r_kmod == 3'd0) begin
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
    end else if (Nk == 8 && r_kmod == 3'd4) begin
      w_temp = sub_word(w_prev);
    end else begin
      w_temp = w_prev;
    end
    w_new_word = r_w[r_idx - NK6] ^ w_temp;
  end

  // One inverse round on the state register, selected by the round counter.
  always_comb begin
    w_isr = 128'h0;
    w_isb = 128'h0;
    w_imc = 128'h0;
    w_rk  = {r_w[{r_rnd, 2'b00}], r_w[{r_rnd, 2'b01}], r_w[{r_rnd, 2'b10}], r_w[{r_rnd, 2'b11}]};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[127-8*(4*c+r) -: 8] = r_blk[127-8*(4*((c - r + 4) % 4)+r) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) w_isb[127-8*k -: 8] = inv_sbox(w_isr[127-8*k -: 8]);
    w_ark = w_isb ^ w_rk;
    for (int c = 0; c < 4; c++) w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    if (r_rnd == 4'(Nr)) begin
      w_next = r_blk ^ w_rk;
    end else if (r_rnd == 4'd0) begin
      w_next = w_ark;
    end else begin
      w_next = w_imc;
    end
  end

  // Control FSM with all state, schedule and handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_blk       <= 128'h0;
      r_out       <= 128'h0;
      for (int i = 0; i < NW; i++) r_w[i] <= 32'h0;
      r_idx       <= 6'd0;
      r_rnd       <= 4'd0;
      r_kmod      <= 3'd0;
      r_rcon      <= 8'h00;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_blk <= in;
            for (int i = 0; i < Nk; i++) r_w[i] <= key[N-1-32*i -: 32];
            r_idx      <= NK6;
            r_kmod     <= 3'd0;
            r_rcon     <= 8'h01;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_KEXP;
          end
        end
        S_KEXP: begin
          r_w[r_idx] <= w_new_word;
          r_idx      <= r_idx + 6'd1;
          r_kmod     <= (r_kmod == 3'(Nk - 1)) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
          if (r_idx == 6'(NW - 1)) begin
            r_rnd   <= 4'(Nr);
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_blk <= w_next;
          if (r_rnd == 4'd0) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: a forward-cipher model produces ciphertexts from known
// plaintexts, and a per-cycle process checks the AES-128 instance against it.
module tb_aes_decrypt_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [127:0] in_128, key_128, out_128;
  logic         iv_128, ir_128, ov_128, or_128, busy_128;
  logic [127:0] in_192, out_192, in_256, out_256;
  logic [191:0] key_192;
  logic [255:0] key_256;
  logic         iv_x, or_x, ir_192, ov_192, busy_192, ir_256, ov_256, busy_256;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192_CT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam int LAT128 = 51;

  aes_decrypt_iter #(.N(128), .Nr(10), .Nk(4)) u128 (
    .clk(clk), .rst_n(rst_n), .in(in_128), .key(key_128), .in_valid(iv_128),
    .in_ready(ir_128), .out(out_128), .out_valid(ov_128), .out_ready(or_128), .busy(busy_128));
  aes_decrypt_iter #(.N(192), .Nr(12), .Nk(6)) u192 (
    .clk(clk), .rst_n(rst_n), .in(in_192), .key(key_192), .in_valid(iv_x),
    .in_ready(ir_192), .out(out_192), .out_valid(ov_192), .out_ready(or_x), .busy(busy_192));
  aes_decrypt_iter #(.N(256), .Nr(14), .Nk(8)) u256 (
    .clk(clk), .rst_n(rst_n), .in(in_256), .key(key_256), .in_valid(iv_x),
    .in_ready(ir_256), .out(out_256), .out_valid(ov_256), .out_ready(or_x), .busy(busy_256));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box table: brute-force field inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int n = 1; n < 5; n++) begin
        d = {inv, inv} << n;
        s = s ^ d[15:8];
      end
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Forward AES cipher; key is left-justified in 256 bits.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key, input int nk);
    int nr;
    logic [31:0] w [60];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] res;
    nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c + r) % 4)+r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd+k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Per-cycle model of the AES-128 instance: phase 0 idle, 1 busy, 2 result held.
  int m_phase = 0;
  int m_cnt = 0;
  logic [127:0] m_pt = 128'h0;
  logic [127:0] m_out = 128'h0;
  logic [127:0] drv_pt = 128'h0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_phase = 0;
      m_out = 128'h0;
    end else begin
      case (m_phase)
        0: if (iv_128) begin m_phase = 1; m_cnt = 0; m_pt = drv_pt; end
        1: begin
          m_cnt++;
          if (m_cnt == LAT128) begin m_phase = 2; m_out = m_pt; end
        end
        default: if (or_128) m_phase = 0;
      endcase
    end
    check("cyc_in_ready", 128'(ir_128), 128'(m_phase == 0));
    check("cyc_busy", 128'(busy_128), 128'(m_phase == 1));
    check("cyc_out_valid", 128'(ov_128), 128'(m_phase == 2));
    check("cyc_out", out_128, m_out);
  end

  task automatic send128(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
    int guard = 0;
    @(negedge clk);
    while (ir_128 !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_timeout", 128'(guard < 300), 128'(1));
    in_128 = ct; key_128 = k; drv_pt = pt; iv_128 = 1'b1;
    @(negedge clk);
    iv_128 = 1'b0;
  endtask

  task automatic drive_rand();
    logic [127:0] p, k;
    p = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    in_128 = aes_enc(p, {k, 128'h0}, 4);
    key_128 = k;
    drv_pt = p;
  endtask

  // Called at the negedge right after the accepting edge; optionally scrambles inputs while busy.
  task automatic wait_out128(input logic [127:0] exp, input bit junk);
    int n = 0;
    while (ov_128 !== 1'b1 && n < 200) begin
      if (junk) begin
        drive_rand();
        iv_128 = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    iv_128 = 1'b0;
    check("latency128", 128'(n), 128'(LAT128));
    check("result128", out_128, exp);
  endtask

  task automatic release_out();
    logic [127:0] held;
    held = out_128;
    or_128 = 1'b1;
    @(negedge clk);
    or_128 = 1'b0;
    check("rel_out_valid", 128'(ov_128), 128'(0));
    check("rel_in_ready", 128'(ir_128), 128'(1));
    check("rel_out_kept", out_128, held);
  endtask

  initial begin
    logic [127:0] p, k;
    int l192, l256;
    build_sbox();
    check("model_b", aes_enc(B_PT, {B_KEY, 128'h0}, 4), B_CT);
    check("model_c128", aes_enc(C_PT, {C_KEY, 128'h0}, 4), C_CT);
    check("model_c192", aes_enc(C_PT, {K192, 64'h0}, 6), C192_CT);
    check("model_c256", aes_enc(C_PT, K256, 8), C256_CT);

    in_128 = 128'h0; key_128 = 128'h0; iv_128 = 1'b0; or_128 = 1'b0;
    in_192 = 128'h0; key_192 = 192'h0; in_256 = 128'h0; key_256 = 256'h0;
    iv_x = 1'b0; or_x = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(ir_128), 128'(1));
    check("rst_out_valid", 128'(ov_128), 128'(0));
    check("rst_busy", 128'(busy_128), 128'(0));
    check("rst_out", out_128, 128'h0);
    rst_n = 1'b1;

    // App. B vector with 20 cycles of backpressure.
    send128(B_CT, B_KEY, B_PT);
    wait_out128(B_PT, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out", out_128, B_PT);
      check("bp_out_valid", 128'(ov_128), 128'(1));
      check("bp_in_ready", 128'(ir_128), 128'(0));
    end
    release_out();

    // Asynchronous reset while the round counter is at 5.
    @(negedge clk);
    in_128 = B_CT; key_128 = B_KEY; drv_pt = B_PT; iv_128 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_128 = 1'b0;
    repeat (45) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", out_128, 128'h0);
    check("arst_out_valid", 128'(ov_128), 128'(0));
    check("arst_busy", 128'(busy_128), 128'(0));
    check("arst_in_ready", 128'(ir_128), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send128(B_CT, B_KEY, B_PT);
    wait_out128(B_PT, 1'b0);
    release_out();

    // Input hold-off, then back-to-back App. B and App. C-128 blocks.
    send128(B_CT, B_KEY, B_PT);
    wait_out128(B_PT, 1'b1);
    in_128 = C_CT; key_128 = C_KEY; drv_pt = C_PT; iv_128 = 1'b1; or_128 = 1'b1;
    @(negedge clk);
    or_128 = 1'b0;
    @(negedge clk);
    iv_128 = 1'b0;
    wait_out128(C_PT, 1'b1);
    release_out();

    // Random blocks with gaps, scrambled inputs while busy and random backpressure.
    for (int b = 0; b < 8; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send128(aes_enc(p, {k, 128'h0}, 4), k, p);
      wait_out128(p, 1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      release_out();
    end

    // AES-192 and AES-256 instances in parallel.
    @(negedge clk);
    check("x_in_ready192", 128'(ir_192), 128'(1));
    check("x_in_ready256", 128'(ir_256), 128'(1));
    in_192 = C192_CT; key_192 = K192; in_256 = C256_CT; key_256 = K256; iv_x = 1'b1;
    @(negedge clk);
    iv_x = 1'b0;
    l192 = -1; l256 = -1;
    for (int n = 0; n < 100 && (l192 < 0 || l256 < 0); n++) begin
      if (ov_192 === 1'b1 && l192 < 0) l192 = n;
      if (ov_256 === 1'b1 && l256 < 0) l256 = n;
      if (l192 < 0 || l256 < 0) @(negedge clk);
    end
    check("latency192", 128'(l192), 128'(59));
    check("latency256", 128'(l256), 128'(67));
    check("result192", out_192, C_PT);
    check("result256", out_256, C_PT);
    or_x = 1'b1;
    @(negedge clk);
    or_x = 1'b0;
    check("rel192_out_valid", 128'(ov_192), 128'(0));
    check("rel256_in_ready", 128'(ir_256), 128'(1));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
